rr_sel_arbiter4: RTL

- 4-requester round-robin arbiter that generates the 2-bit select for the downstream 4:1 mux (i_sel input of mux4_1).
- Sits directly upstream of the mux: o_sel drives mux4_1.i_sel, and o_valid qualifies mux output o.
- Enforces fairness with a rotating priority pointer.
- Bounds grant tenure with an optional burst-length limit.

---
 rtl/mux_sel_pkg.sv | 55 +++++
 rtl/mux4_1.sv | 27 ++
 rtl/rr_pick4.sv | 25 ++
 rtl/rr_sel_arbiter4.sv | 142 ++++++++++++++
 4 files changed

// File: rtl/mux_sel_pkg.sv
// Shared definitions for the round-robin select arbiter that drives mux4_1.i_sel.
// Contents:
//   N_SRC / SEL_W - number of mux sources and width of the select
//   arb_state_e   - arbiter FSM states
//   pick_t        - {found, idx} result of a rotate-priority scan
//   rr_pick       - rotate-priority scan starting at a pointer
//   sel_onehot    - one-hot grant vector for a (valid, sel) pair
package mux_sel_pkg;

  localparam int N_SRC = 4;
  localparam int SEL_W = 2;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } arb_state_e;

  typedef struct packed {
    logic             found;
    logic [SEL_W-1:0] idx;
  } pick_t;

  // Scan ptr, ptr+1, ptr+2, ptr+3 (mod 4) and return the first requester.
  // The loop runs from the farthest offset down so the nearest hit is written last.
  function automatic pick_t rr_pick(input logic [SEL_W-1:0] ptr,
                                    input logic [N_SRC-1:0] req);
    pick_t            res;
    logic [SEL_W-1:0] k;
    res.found = 1'b0;
    res.idx   = {SEL_W{1'b0}};
    for (int i = N_SRC - 1; i >= 0; i--) begin
      k = ptr + i[SEL_W-1:0];
      if (req[k]) begin
        res.found = 1'b1;
        res.idx   = k;
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

  // One-hot grant for a selected index, or all-zero when not valid.
  function automatic logic [N_SRC-1:0] sel_onehot(input logic             valid,
                                                  input logic [SEL_W-1:0] sel);
    logic [N_SRC-1:0] oh;
    if (valid) begin
      oh = {{(N_SRC-1){1'b0}}, 1'b1} << sel;
    end else begin
      oh = {N_SRC{1'b0}};
    end
    return oh;
  endfunction

endpackage

// File: rtl/mux4_1.sv
// Plain 4:1 single-bit multiplexer fed by the arbiter select.
// Ports:
//   i0..i3       - data inputs
//   i_sel  [1:0] - select
//   o            - selected data
module mux4_1 (
  input  logic       i0,
  input  logic       i1,
  input  logic       i2,
  input  logic       i3,
  input  logic [1:0] i_sel,
  output logic       o
);

  // Select one of four inputs.
  always_comb begin
    o = 1'b0;
    case (i_sel)
      2'd0:    o = i0;
      2'd1:    o = i1;
      2'd2:    o = i2;
      2'd3:    o = i3;
      default: o = 1'b0;
    endcase
  end

endmodule

// File: rtl/rr_pick4.sv
// Combinational rotate-priority encoder for four requesters.
// Ports:
//   ptr_i   [1:0] - index with highest priority
//   req_i   [3:0] - request vector
//   found_o       - at least one request present
//   idx_o   [1:0] - first requesting index scanning upward from ptr_i (mod 4)
module rr_pick4
  import mux_sel_pkg::*;
(
  input  logic [SEL_W-1:0] ptr_i,
  input  logic [N_SRC-1:0] req_i,
  output logic             found_o,
  output logic [SEL_W-1:0] idx_o
);

  pick_t pick_s;

  // Rotate-priority scan.
  always_comb begin
    pick_s  = rr_pick(ptr_i, req_i);
    found_o = pick_s.found;
    idx_o   = pick_s.idx;
  end

endmodule

// File: rtl/rr_sel_arbiter4.sv
// Four-requester round-robin arbiter producing the select for mux4_1.
// A rotating pointer provides fairness; an optional burst limit bounds how
// long one source can keep the grant.
// Parameters:
//   MAX_BURST - max consecutive grant cycles per tenure, 0 = unlimited
//   CNT_W     - burst counter width, 2**CNT_W must exceed MAX_BURST
// Ports:
//   i_clk         - clock, rising edge
//   i_rst_n       - synchronous active-low reset
//   i_req   [3:0] - request per mux source
//   i_last        - last cycle of the granted transfer (ignored when idle)
//   o_sel   [1:0] - granted index, drives mux4_1.i_sel
//   o_grant [3:0] - one-hot grant, zero when idle
//   o_valid       - grant active
module rr_sel_arbiter4
  import mux_sel_pkg::*;
#(
  parameter int unsigned MAX_BURST = 8,
  parameter int unsigned CNT_W     = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [N_SRC-1:0] i_req,
  input  logic             i_last,
  output logic [SEL_W-1:0] o_sel,
  output logic [N_SRC-1:0] o_grant,
  output logic             o_valid
);

  arb_state_e       state_q, state_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [N_SRC-1:0] grant_q, grant_d;
  logic             valid_q, valid_d;
  logic [SEL_W-1:0] ptr_q, ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [N_SRC-1:0] masked_req_s;
  logic             burst_hit_s;
  logic             release_s;
  logic [SEL_W-1:0] pick_ptr_s;
  logic [N_SRC-1:0] pick_req_s;
  logic             pick_found_s;
  logic [SEL_W-1:0] pick_idx_s;

  // Release detection and arbitration inputs for the current grant holder.
  // While granting, the scan starts just past the holder with the holder
  // masked out, so a handover always moves to another requester if one exists.
  always_comb begin
    masked_req_s = i_req & ~({{(N_SRC-1){1'b0}}, 1'b1} << sel_q);
    burst_hit_s  = (MAX_BURST != 32'd0) && (cnt_q == CNT_W'(MAX_BURST));
    release_s    = i_last || !i_req[sel_q] || burst_hit_s;
    if (state_q == ST_GRANT) begin
      pick_ptr_s = sel_q + 2'd1;
      pick_req_s = masked_req_s;
    end else begin
      pick_ptr_s = ptr_q;
      pick_req_s = i_req;
    end
  end

  rr_pick4 u_pick (
    .ptr_i   (pick_ptr_s),
    .req_i   (pick_req_s),
    .found_o (pick_found_s),
    .idx_o   (pick_idx_s)
  );

  // Next-state, pointer and burst counter.
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    valid_d = valid_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_found_s) begin
          state_d = ST_GRANT;
          sel_d   = pick_idx_s;
          valid_d = 1'b1;
          cnt_d   = CNT_W'(1);
        end else begin
          valid_d = 1'b0;
        end
      end
      ST_GRANT: begin
        if (!release_s) begin
          valid_d = 1'b1;
          if (cnt_q != {CNT_W{1'b1}}) begin
            cnt_d = cnt_q + CNT_W'(1);
          end else begin
            cnt_d = cnt_q;
          end
        end else begin
          ptr_d = sel_q + 2'd1;
          if (pick_found_s) begin
            sel_d   = pick_idx_s;
            valid_d = 1'b1;
            cnt_d   = CNT_W'(1);
          end else if (i_req[sel_q]) begin
            // Holder still requesting: release came from i_last or the
            // burst limit and nobody else wants the mux, so re-grant it.
            valid_d = 1'b1;
            cnt_d   = CNT_W'(1);
          end else begin
            state_d = ST_IDLE;
            valid_d = 1'b0;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        valid_d = 1'b0;
      end
    endcase
    grant_d = sel_onehot(valid_d, sel_d);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
      sel_q   <= 2'b00;
      grant_q <= 4'b0000;
      valid_q <= 1'b0;
      ptr_q   <= 2'b00;
      cnt_q   <= {CNT_W{1'b0}};
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      grant_q <= grant_d;
      valid_q <= valid_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

  assign o_sel   = sel_q;
  assign o_grant = grant_q;
  assign o_valid = valid_q;

endmodule
